disp_hex_multi: RTL

//  Parametrised N-digit hexadecimal 7-segment driver, next generation of the two-digit hex display.
//  - Captures a DIGITS*4-bit value on a load strobe and holds it between strobes.
//  - Adds leading-zero blanking, a per-digit blanking mask, per-digit blink with an internal prescaler,
//    and a one-cycle change flag.
//  - Sits between any value source (instruction pointer, registers, debug bus) and the board HEX displays.

---
 rtl/disp_hex_multi.sv | 133 +++++++++++++
 1 files changed

// File: rtl/disp_hex_multi.sv
// disp_hex_multi: N-digit hexadecimal 7-segment driver with load capture,
// leading-zero blanking, per-digit blanking mask, per-digit blink and a
// one-cycle change flag. All outputs are registered.
module disp_hex_multi #(
  parameter int DIGITS         = 4,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [7*DIGITS-1:0]   segs,
  output logic                  changed
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
  localparam logic [7*DIGITS-1:0] SEGS_DARK = {(7*DIGITS){SEG_ACTIVE_LOW}};

  logic [4*DIGITS-1:0] held_q, held_d;
  logic                valid_q, valid_d;
  logic                changed_q, changed_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [7*DIGITS-1:0] segs_q, segs_d;

  logic [3:0]          digit;
  logic                upperZero;
  logic                dark;
  logic [6:0]          pattern;

  // Active-high gfedcba pattern for one hex digit.
  function automatic logic [6:0] decodeHex(input logic [3:0] d);
    case (d)
      4'h0: decodeHex = 7'h3F;
      4'h1: decodeHex = 7'h06;
      4'h2: decodeHex = 7'h5B;
      4'h3: decodeHex = 7'h4F;
      4'h4: decodeHex = 7'h66;
      4'h5: decodeHex = 7'h6D;
      4'h6: decodeHex = 7'h7D;
      4'h7: decodeHex = 7'h07;
      4'h8: decodeHex = 7'h7F;
      4'h9: decodeHex = 7'h6F;
      4'hA: decodeHex = 7'h77;
      4'hB: decodeHex = 7'h7C;
      4'hC: decodeHex = 7'h39;
      4'hD: decodeHex = 7'h5E;
      4'hE: decodeHex = 7'h79;
      default: decodeHex = 7'h71;
    endcase
  endfunction

  // Capture path: held value, "has been loaded" flag and the change pulse.
  always_comb begin
    held_d    = held_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    if (load) begin
      held_d    = data_in;
      valid_d   = 1'b1;
      changed_d = (data_in != held_q);
    end
  end

  // Free-running blink prescaler; phase flips on the wrap back to zero.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Per-digit decode walking from the top digit so the leading-zero run is known.
  always_comb begin
    segs_d    = SEGS_DARK;
    digit     = 4'h0;
    upperZero = 1'b1;
    dark      = 1'b1;
    pattern   = 7'h00;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      digit     = held_q[4*i +: 4];
      upperZero = upperZero & (digit == 4'h0);
      dark      = ~valid_q | blank[i] | (lz_en & upperZero & (i != 0))
                | (blink_en[i] & ~phase_q);
      pattern   = dark ? 7'h00 : decodeHex(digit);
      segs_d[7*i +: 7] = SEG_ACTIVE_LOW ? ~pattern : pattern;
    end
  end

  // Capture registers; the display stays dark after reset until the first load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q    <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      held_q    <= held_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  // Blink counter and phase registers; phase 1 means digits are lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Output segment register, recomputed every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segs_q <= SEGS_DARK;
    end else begin
      segs_q <= segs_d;
    end
  end

  assign segs    = segs_q;
  assign changed = changed_q;

endmodule
